// File: rtl/mem_stage_dcache_if.sv
// mem_stage_dcache_if -- pipeline MEM stage with data-cache load/store handshake.
// Captures an aligned memory op into request registers, holds the pipeline
// stalled until the cache responds, and registers the MEM/WB results.
// Misaligned accesses are suppressed and flagged with a one-cycle pulse.
// Optional feature: define MEM_STALL_CNT_EN to add stall_cnt_out, a
// free-running (wrapping) count of cycles with stall_out asserted.
module mem_stage_dcache_if #(
  parameter int STALL_CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_in,
  input  logic        mem_load_in,
  input  logic        mem_store_in,
  input  logic [2:0]  mem_funct3_in,
  input  logic [31:0] mem_alu_in,
  input  logic [31:0] mem_rs2_in,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  output logic        stall_out,
  output logic        wb_valid_out,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mem_out,
  output logic        misalign_out
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_out
`endif
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t      r_state;

  // Request registers: authoritative for the whole BUSY period.
  logic        r_is_load;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;

  // MEM/WB registers.
  logic        r_wb_valid;
  logic [31:0] r_wb_alu;
  logic [31:0] r_wb_mem;
  logic        r_misalign;

  logic [1:0]  w_off;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_aligned;
  logic        w_mem_op;
  logic        w_accept;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rshift;
  logic [31:0] w_load_data;

  // Access size comes from funct3[1:0]; 10 and 11 (incl. illegal codes) are word.
  assign w_off      = mem_alu_in[1:0];
  assign w_is_byte  = (mem_funct3_in[1:0] == 2'b00);
  assign w_is_half  = (mem_funct3_in[1:0] == 2'b01);
  assign w_aligned  = w_is_byte || (w_is_half && !w_off[0]) || (w_off == 2'b00);
  assign w_mem_op   = mem_valid_in && (mem_load_in || mem_store_in);
  assign w_accept   = (r_state == S_IDLE) && w_mem_op && w_aligned;
  assign w_misalign = (r_state == S_IDLE) && w_mem_op && !w_aligned;

  // Byte enables and lane-replicated store data for the incoming op.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    w_be    = 4'b1111;
    w_wdata = mem_rs2_in;
    if (w_is_byte) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{mem_rs2_in[7:0]}};
    end else if (w_is_half) begin
      w_be    = 4'b0011 << w_off;
      w_wdata = {2{mem_rs2_in[15:0]}};
    end
  end

  // Extract and extend the addressed byte/half from the returning cache word.
  assign w_rshift = dmem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_data = dmem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_rshift[7]}}, w_rshift[7:0]};
      3'b100:  w_load_data = {24'd0, w_rshift[7:0]};
      3'b001:  w_load_data = {{16{w_rshift[15]}}, w_rshift[15:0]};
      3'b101:  w_load_data = {16'd0, w_rshift[15:0]};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // Cache requests come only from registers, so an async reset drops them at once.
  assign dmem_read        = (r_state == S_BUSY) && r_is_load;
  assign dmem_write       = (r_state == S_BUSY) && !r_is_load;
  assign dmem_address     = {r_addr[31:2], 2'b00};
  assign dmem_wdata       = r_wdata;
  assign dmem_byte_enable = r_be;

  assign stall_out    = w_accept || ((r_state == S_BUSY) && !dmem_resp);
  assign wb_valid_out = r_wb_valid;
  assign wb_alu_out   = r_wb_alu;
  assign wb_mem_out   = r_wb_mem;
  assign misalign_out = r_misalign;

  // FSM: accept in IDLE, wait for the cache in BUSY, register WB results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_load  <= 1'b0;
      r_addr     <= 32'd0;
      r_funct3   <= 3'd0;
      r_wdata    <= 32'd0;
      r_be       <= 4'd0;
      r_wb_valid <= 1'b0;
      r_wb_alu   <= 32'd0;
      r_wb_mem   <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order inside this block.
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_BUSY;
            r_is_load <= mem_load_in;
            r_addr    <= mem_alu_in;
            r_funct3  <= mem_funct3_in;
            r_wdata   <= w_wdata;
            r_be      <= w_be;
          end else if (mem_valid_in) begin
            // Non-memory or suppressed misaligned op: pass straight to WB.
            r_wb_valid <= 1'b1;
            r_wb_alu   <= mem_alu_in;
            r_wb_mem   <= 32'd0;
            r_misalign <= w_misalign;
          end
        end
        S_BUSY: begin
          if (dmem_resp) begin
            r_state    <= S_IDLE;
            r_wb_valid <= 1'b1;
            r_wb_alu   <= r_addr;
            r_wb_mem   <= r_is_load ? w_load_data : 32'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Count stalled cycles; wraps naturally at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_out) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_out = r_stall_cnt;
`endif

endmodule

// File: doc/mem_stage_dcache_if.md
Name: mem_stage_dcache_if

Overview:
- Pipeline MEM stage: takes EX/MEM results, performs the load/store handshake with the data cache, and produces the registered MEM/WB values consumed by writeback.
- Holds the pipeline stalled while a cache access is outstanding.
- Handles byte/half/word alignment: byte-enables and shifted store data on the way out; extracted, sign/zero-extended load data on the way back.

Parameters:
- STALL_CNT_W, 32, width of the optional stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_valid_in  in  1  EX/MEM slot holds a valid instruction
- mem_load_in  in  1  instruction is a load
- mem_store_in  in  1  instruction is a store
- mem_funct3_in  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- mem_alu_in  in  32  ALU result; byte address for loads/stores
- mem_rs2_in  in  32  store source data
- dmem_resp  in  1  cache completion strobe
- dmem_rdata  in  32  cache read word, valid with dmem_resp
- dmem_read  out  1  cache read request
- dmem_write  out  1  cache write request
- dmem_address  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_wdata  out  32  store data shifted into byte lanes
- dmem_byte_enable  out  4  active byte lanes
- stall_out  out  1  upstream must hold inputs and not advance
- wb_valid_out  out  1  WB register valid
- wb_alu_out  out  32  registered ALU result
- wb_mem_out  out  32  registered extended load data
- misalign_out  out  1  one-cycle pulse: misaligned access suppressed

Behaviour:
- Reset: state IDLE; all outputs 0. Asynchronous assertion aborts any outstanding access at once: dmem_read/dmem_write drop immediately.
- FSM states:
  - IDLE: a cycle with mem_valid_in && (load|store) && aligned captures addr, funct3, shifted data and byte-enable into request registers, goes to BUSY, and asserts stall_out combinationally that cycle.
  - BUSY: drives dmem_read or dmem_write from the request registers and asserts stall_out while !dmem_resp. On dmem_resp: stall_out low that cycle; the next edge loads wb_mem_out and wb_alu_out, pulses wb_valid_out, and returns to IDLE.
- Latency:
  - Memory op accepted at T: request visible T+1; response at cycle R gives WB valid at R+1.
  - Non-memory valid op: wb_alu_out = mem_alu_in, wb_mem_out = 0, wb_valid_out = 1 at T+1. No stall.
- Alignment: h/hu requires addr[0]=0; w requires addr[1:0]=0. A misaligned op issues no cache request and does not stall; it pulses misalign_out and gives wb_valid_out=1 with wb_mem_out=0 at T+1.
- Byte enables by addr[1:0]: b gives 4'b0001<<off; h gives 4'b0011<<off; w gives 4'b1111. Store data is rs2 low bits replicated/shifted so lane k holds byte k.
- Load extract: byte rdata[8*off+:8], half rdata[8*off+:16]. b/h sign-extend; bu/hu zero-extend; w passes through. An illegal funct3 is treated as w.
- Write response: wb_mem_out = 0.
- Exclusivity: dmem_read and dmem_write are never both 1. dmem_* outputs are stable throughout BUSY.
- dmem_resp while IDLE, including after a reset abort, is ignored.
- Invalid input slot: wb_valid_out = 0 next cycle; WB data registers hold their previous values.
- Inputs are ignored while BUSY; the request registers are authoritative.

Optional Feature:
- Macro MEM_STALL_CNT_EN.
- Defined: extra output stall_cnt_out [STALL_CNT_W-1:0]. Increments by 1 each cycle stall_out=1 and wraps at all-ones. Reset clears it to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- lw addr 0x1004, cache resp after 3 BUSY cycles with rdata 0xDEADBEEF -> dmem_read high 3 cycles, address 0x1004, be 4'b1111; wb_mem_out=0xDEADBEEF and wb_valid_out=1 one cycle after resp.
- lb addr 0x2003, rdata 0x80FF_0000 -> wb_mem_out=0xFFFFFF80; same access as lbu -> 0x00000080.
- sh addr 0x3002, rs2 0x0000ABCD -> dmem_write=1, address 0x3000, be 4'b1100, wdata[31:16]=0xABCD; wb_mem_out=0.
- lw addr 0x4001 -> no dmem request, stall_out=0, misalign_out pulse, wb_valid_out=1 with wb_mem_out=0.
- Assert rst during BUSY then send dmem_resp in IDLE -> dmem_read drops in the reset cycle, stray resp ignored, wb_valid_out stays 0.
- MEM_STALL_CNT_EN defined: two loads with 4-cycle and 2-cycle cache waits -> stall_cnt_out=8 (accept cycle plus wait cycles for each load).
